// File: rtl/mult_div_unit_pkg.sv
// rtl/mult_div_unit_pkg.sv - op codes, FSM states and signed/unsigned divide helper for mult_div_unit
package mult_div_unit_pkg;

  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVU  = 4'd3,
    OP_MTHI  = 4'd4,
    OP_MTLO  = 4'd5,
    OP_MADD  = 4'd6,
    OP_MADDU = 4'd7,
    OP_MSUB  = 4'd8,
    OP_MSUBU = 4'd9
  } md_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_t;

  // Returns {remainder, quotient}. Works on magnitudes so 0x80000000 / -1
  // never overflows: the quotient magnitude 0x80000000 wraps back to itself.
  function automatic logic [63:0] div_result(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic        is_signed);
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] q;
    logic [31:0] r;
    neg_a = is_signed & a[31];
    neg_b = is_signed & b[31];
    mag_a = neg_a ? (~a + 32'd1) : a;
    mag_b = neg_b ? (~b + 32'd1) : b;
    q = (mag_b == '0) ? '0 : (mag_a / mag_b);
    r = (mag_b == '0) ? '0 : (mag_a % mag_b);
    if (neg_a ^ neg_b) q = ~q + 32'd1;
    if (neg_a)         r = ~r + 32'd1;
    return {r, q};
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multi-cycle HI/LO multiply/divide unit; MADD/MSUB family enabled by MULT_DIV_MADD_EN
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

  md_state_t   state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic [63:0] result_q, result_d;
  logic [31:0] hi_d, lo_d;

  logic [63:0] prod_s, prod_u, div_s, div_u;

  // Sign/zero extension to 64 bits makes a plain 64-bit multiply exact for both flavours.
  assign prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
  assign prod_u = {32'd0, rs} * {32'd0, rt};
  assign div_s  = div_result(rs, rt, 1'b1);
  assign div_u  = div_result(rs, rt, 1'b0);

`ifdef MULT_DIV_MADD_EN
  logic [63:0] acc;
  assign acc = {hi, lo};
`endif

  assign busy = (state_q != ST_IDLE);

  // Next-state, countdown and result latching; HI/LO only move on completion or MTHI/MTLO.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    result_d = result_q;
    hi_d     = hi;
    lo_d     = lo;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT:  begin result_d = prod_s; count_d = MULT_CNT; state_d = ST_MUL; end
            OP_MULTU: begin result_d = prod_u; count_d = MULT_CNT; state_d = ST_MUL; end
            // Divide by zero latches the current HI/LO so completion rewrites them unchanged.
            OP_DIV:   begin result_d = (rt == '0) ? {hi, lo} : div_s; count_d = DIV_CNT; state_d = ST_DIV; end
            OP_DIVU:  begin result_d = (rt == '0) ? {hi, lo} : div_u; count_d = DIV_CNT; state_d = ST_DIV; end
            OP_MTHI:  hi_d = rs;
            OP_MTLO:  lo_d = rs;
`ifdef MULT_DIV_MADD_EN
            OP_MADD:  begin result_d = acc + prod_s; count_d = MULT_CNT; state_d = ST_MUL; end
            OP_MADDU: begin result_d = acc + prod_u; count_d = MULT_CNT; state_d = ST_MUL; end
            OP_MSUB:  begin result_d = acc - prod_s; count_d = MULT_CNT; state_d = ST_MUL; end
            OP_MSUBU: begin result_d = acc - prod_u; count_d = MULT_CNT; state_d = ST_MUL; end
`endif
            default: ;
          endcase
        end
      end
      ST_MUL, ST_DIV: begin
        if (count_q == 4'd1) begin
          {hi_d, lo_d} = result_q;
          count_d      = 4'd0;
          state_d      = ST_IDLE;
        end else begin
          count_d = count_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = 4'd0;
      end
    endcase
  end

  // State, counter, latched result and architectural HI/LO registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      count_q  <= 4'd0;
      result_q <= 64'd0;
      hi       <= 32'd0;
      lo       <= 32'd0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      result_q <= result_d;
      hi       <= hi_d;
      lo       <= lo_d;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - randomized self-checking bench for mult_div_unit against an arithmetic model
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] rs, rt;
  logic        busy;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;
  logic [31:0] m_hi, m_lo;
  int busy_cnt;
  int early_cnt;

  always #5 clk = ~clk;

  mult_div_unit #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs(rs), .rt(rt), .busy(busy), .hi(hi), .lo(lo)
  );

  // Architectural effect of one op on the model HI/LO; returns expected busy cycles.
  function automatic int model_apply(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] acc;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    acc = {m_hi, m_lo};
    case (o)
      OP_MULT:  begin {m_hi, m_lo} = 64'(sa * sb); return MULT_LAT; end
      OP_MULTU: begin {m_hi, m_lo} = 64'(ua * ub); return MULT_LAT; end
      OP_DIV: begin
        if (b != 0) begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
        return DIV_LAT;
      end
      OP_DIVU: begin
        if (b != 0) begin m_lo = 32'(ua / ub); m_hi = 32'(ua % ub); end
        return DIV_LAT;
      end
      OP_MTHI: begin m_hi = a; return 0; end
      OP_MTLO: begin m_lo = a; return 0; end
`ifdef MULT_DIV_MADD_EN
      OP_MADD:  begin {m_hi, m_lo} = acc + 64'(sa * sb); return MULT_LAT; end
      OP_MADDU: begin {m_hi, m_lo} = acc + 64'(ua * ub); return MULT_LAT; end
      OP_MSUB:  begin {m_hi, m_lo} = acc - 64'(sa * sb); return MULT_LAT; end
      OP_MSUBU: begin {m_hi, m_lo} = acc - 64'(ua * ub); return MULT_LAT; end
`endif
      default: return 0;
    endcase
  endfunction

  // Issue one op and count busy cycles; early_cnt counts busy cycles where HI/LO already moved.
  task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] pre_hi, pre_lo;
    pre_hi = hi;
    pre_lo = lo;
    @(negedge clk);
    start = 1'b1; op = o; rs = a; rt = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    busy_cnt  = 0;
    early_cnt = 0;
    while (busy === 1'b1 && busy_cnt < 40) begin
      busy_cnt++;
      if (hi !== pre_hi || lo !== pre_lo) early_cnt++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 4'd0; rs = '0; rt = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b hi=%h lo=%h, expected busy=0 hi=0 lo=0", busy, hi, lo);
    end
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
  endtask

  task automatic test_mult_directed();
    int lat;
    lat = model_apply(OP_MULT, 32'hFFFFFFFE, 32'd3);
    do_op(OP_MULT, 32'hFFFFFFFE, 32'd3);
    checks++;
    if (busy_cnt !== 5 || lat !== 5) begin errors++; $display("FAIL mult_neg_latency: busy cycles %0d, expected 5", busy_cnt); end
    checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin
      errors++; $display("FAIL mult_neg_value: hi=%h lo=%h, expected hi=ffffffff lo=fffffffa", hi, lo);
    end
    lat = model_apply(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    do_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    checks++;
    if (busy_cnt !== 5 || early_cnt !== 0) begin errors++; $display("FAIL multu_latency: busy cycles %0d early %0d, expected 5 and 0", busy_cnt, early_cnt); end
    checks++;
    if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
      errors++; $display("FAIL multu_value: hi=%h lo=%h, expected hi=fffffffe lo=00000001", hi, lo);
    end
  endtask

  task automatic test_div_directed();
    int lat;
    lat = model_apply(OP_DIV, 32'hFFFFFFF9, 32'd2);
    do_op(OP_DIV, 32'hFFFFFFF9, 32'd2);
    checks++;
    if (busy_cnt !== 10) begin errors++; $display("FAIL div_neg_latency: busy cycles %0d, expected 10", busy_cnt); end
    checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
      errors++; $display("FAIL div_neg_value: hi=%h lo=%h, expected hi=ffffffff lo=fffffffd", hi, lo);
    end
    lat = model_apply(OP_DIVU, 32'd7, 32'd0);
    do_op(OP_DIVU, 32'd7, 32'd0);
    checks++;
    if (busy_cnt !== 10) begin errors++; $display("FAIL divu_zero_latency: busy cycles %0d, expected 10", busy_cnt); end
    checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
      errors++; $display("FAIL divu_zero_unchanged: hi=%h lo=%h, expected hi=ffffffff lo=fffffffd", hi, lo);
    end
    lat = model_apply(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    do_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    checks++;
    if (hi !== 32'h00000000 || lo !== 32'h80000000 || busy_cnt !== lat) begin
      errors++; $display("FAIL div_overflow: hi=%h lo=%h busy %0d, expected hi=00000000 lo=80000000 busy %0d", hi, lo, busy_cnt, lat);
    end
  endtask

  task automatic test_move();
    int lat;
    lat = model_apply(OP_MTLO, 32'h1234, 32'h0);
    do_op(OP_MTLO, 32'h1234, 32'hDEAD);
    checks++;
    if (busy_cnt !== 0 || lo !== 32'h1234 || hi !== m_hi) begin
      errors++; $display("FAIL mtlo: busy %0d hi=%h lo=%h, expected busy 0 hi=%h lo=00001234", busy_cnt, hi, lo, m_hi);
    end
    lat = model_apply(OP_MTHI, 32'hCAFE0001, 32'h0);
    do_op(OP_MTHI, 32'hCAFE0001, 32'h5);
    checks++;
    if (busy_cnt !== 0 || hi !== 32'hCAFE0001 || lo !== 32'h1234) begin
      errors++; $display("FAIL mthi: busy %0d hi=%h lo=%h, expected busy 0 hi=cafe0001 lo=00001234", busy_cnt, hi, lo);
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    int cnt;
    lat = model_apply(OP_MULT, 32'd1000, 32'hFFFFFFF0);
    @(negedge clk);
    start = 1'b1; op = OP_MULT; rs = 32'd1000; rt = 32'hFFFFFFF0;
    @(posedge clk);
    #1;
    start = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      cnt++;
      @(negedge clk);
      if (cnt == 2) begin start = 1'b1; op = OP_MULT; rs = 32'd7; rt = 32'd9; end
      if (cnt == 3) begin start = 1'b1; op = OP_MTHI; rs = 32'h0BAD0BAD; end
      if (cnt == 4) begin start = 1'b1; op = OP_DIV;  rs = 32'd50; rt = 32'd3; end
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    checks++;
    if (cnt !== lat) begin errors++; $display("FAIL busy_ignore_latency: busy cycles %0d, expected %0d", cnt, lat); end
    checks++;
    if (hi !== m_hi || lo !== m_lo) begin
      errors++; $display("FAIL busy_ignore_value: hi=%h lo=%h, expected hi=%h lo=%h", hi, lo, m_hi, m_lo);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
      errors++; $display("FAIL busy_ignore_after: busy=%b hi=%h lo=%h, expected busy=0 hi=%h lo=%h", busy, hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_undefined();
    int lat;
    int last_op;
`ifdef MULT_DIV_MADD_EN
    last_op = 10;
`else
    last_op = 6;
`endif
    for (int o = 15; o >= last_op; o--) begin
      lat = model_apply(4'(o), $urandom, $urandom);
      do_op(4'(o), $urandom, $urandom);
      checks++;
      if (busy_cnt !== 0 || hi !== m_hi || lo !== m_lo) begin
        errors++; $display("FAIL undefined_op_%0d: busy %0d hi=%h lo=%h, expected busy 0 hi=%h lo=%h", o, busy_cnt, hi, lo, m_hi, m_lo);
      end
    end
  endtask

  task automatic test_random();
    int lat;
    logic [3:0] o;
    logic [31:0] a, b;
    logic [3:0] ops [6];
    ops = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO};
    for (int i = 0; i < 40; i++) begin
      o = ops[$urandom_range(0, 5)];
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'(int'($urandom_range(0, 20)) - 10);
        2: a = 32'h80000000;
        default: ;
      endcase
      lat = model_apply(o, a, b);
      do_op(o, a, b);
      checks++;
      if (busy_cnt !== lat || early_cnt !== 0) begin
        errors++; $display("FAIL random_%0d_latency: op %0d busy %0d early %0d, expected busy %0d early 0", i, o, busy_cnt, early_cnt, lat);
      end
      checks++;
      if (hi !== m_hi || lo !== m_lo) begin
        errors++; $display("FAIL random_%0d_value: op %0d a=%h b=%h hi=%h lo=%h, expected hi=%h lo=%h", i, o, a, b, hi, lo, m_hi, m_lo);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    lat = model_apply(OP_MTHI, 32'hAAAA5555, 32'h0);
    do_op(OP_MTHI, 32'hAAAA5555, 32'h0);
    lat = model_apply(OP_MTLO, 32'h00005A5A, 32'h0);
    do_op(OP_MTLO, 32'h00005A5A, 32'h0);
    @(negedge clk);
    start = 1'b1; op = OP_DIV; rs = 32'd100; rt = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++; $display("FAIL reset_mid_immediate: busy=%b hi=%h lo=%h, expected busy=0 hi=0 lo=0", busy, hi, lo);
    end
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    repeat (15) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++; $display("FAIL reset_mid_after: busy=%b hi=%h lo=%h, expected busy=0 hi=0 lo=0", busy, hi, lo);
    end
  endtask

  task automatic test_madd();
    int lat;
    lat = model_apply(OP_MTHI, 32'd0, 32'd0);
    do_op(OP_MTHI, 32'd0, 32'd0);
    lat = model_apply(OP_MTLO, 32'hFFFFFFFF, 32'd0);
    do_op(OP_MTLO, 32'hFFFFFFFF, 32'd0);
    lat = model_apply(OP_MADDU, 32'd1, 32'd1);
    do_op(OP_MADDU, 32'd1, 32'd1);
`ifdef MULT_DIV_MADD_EN
    checks++;
    if (busy_cnt !== 5 || hi !== 32'd1 || lo !== 32'd0) begin
      errors++; $display("FAIL maddu_carry: busy %0d hi=%h lo=%h, expected busy 5 hi=00000001 lo=00000000", busy_cnt, hi, lo);
    end
    for (int i = 0; i < 12; i++) begin
      logic [3:0] o;
      logic [31:0] a, b;
      o = 4'($urandom_range(6, 9));
      a = $urandom;
      b = $urandom;
      lat = model_apply(o, a, b);
      do_op(o, a, b);
      checks++;
      if (busy_cnt !== lat || hi !== m_hi || lo !== m_lo) begin
        errors++; $display("FAIL madd_random_%0d: op %0d busy %0d hi=%h lo=%h, expected busy %0d hi=%h lo=%h", i, o, busy_cnt, hi, lo, lat, m_hi, m_lo);
      end
    end
`else
    checks++;
    if (busy_cnt !== 0 || hi !== 32'd0 || lo !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL maddu_disabled: busy %0d hi=%h lo=%h, expected busy 0 hi=00000000 lo=ffffffff", busy_cnt, hi, lo);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_mult_directed();
    test_div_directed();
    test_move();
    test_busy_ignore();
    test_undefined();
    test_random();
    test_madd();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter MULT_LAT, default 5, busy cycles for multiply ops (range 1..15).
REQ-002 SHALL have parameter DIV_LAT, default 10, busy cycles for divide ops (range 1..15).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  op issue strobe from the EX stage, one cycle per instruction.
REQ-006 SHALL have port op  input  4  operation code (package constants).
REQ-007 SHALL have port rs  input  32  forwarded rs operand from the ID/EX register.
REQ-008 SHALL have port rt  input  32  forwarded rt operand from the ID/EX register.
REQ-009 SHALL have port busy  output  1  high while a multiply/divide is in flight.
REQ-010 SHALL have port hi  output  32  architectural HI register.
REQ-011 SHALL have port lo  output  32  architectural LO register.

Function
REQ-012 SHALL implement states IDLE, MUL, DIV; busy = (state != IDLE).
REQ-013 SHALL, in IDLE with start=1 and op MULT/MULTU, latch the 64-bit signed/unsigned product of rs*rt, load counter with MULT_LAT, go to MUL.
REQ-014 SHALL, in IDLE with start=1 and op DIV/DIVU, latch quotient/remainder of rs/rt, load counter with DIV_LAT, go to DIV.
REQ-015 SHALL decrement counter each cycle in MUL/DIV; when it reaches 1, write latched result to hi/lo and go to IDLE on that edge.
REQ-016 Latency: start sampled at edge N -> busy high cycles N+1..N+LAT -> hi/lo new value and busy=0 from edge N+LAT.
REQ-017 SHALL write hi (MTHI) or lo (MTLO) with rs on the next edge, without asserting busy, when start=1 in IDLE.
REQ-018 SHALL ignore start while busy (no state, counter or result change); the hazard unit stalls MD instructions in ID when busy or start.
REQ-019 Multiply: hi = product[63:32], lo = product[31:0]; MULT signed, MULTU unsigned.
REQ-020 Divide: lo = quotient truncated toward zero, hi = remainder with sign of dividend; DIVU unsigned.
REQ-021 Signed 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0x00000000.
REQ-022 Divide by zero SHALL still run DIV_LAT busy cycles and leave hi/lo unchanged.
REQ-023 Undefined op with start=1 SHALL be ignored in all states.

Reset
REQ-024 Reset SHALL asynchronously force state=IDLE, counter=0, busy=0, hi=0, lo=0, latched result=0.
REQ-025 Reset mid-operation SHALL abort the op; no partial result reaches hi/lo after reset deasserts.

Configuration
REQ-026 With MULT_DIV_MADD_EN defined, ops MADD/MADDU/MSUB/MSUBU SHALL be supported: {hi,lo} +/- rs*rt (64-bit wrap, signed/unsigned), MULT_LAT busy cycles, accumulator sampled at issue.
REQ-027 Without MULT_DIV_MADD_EN, those op codes SHALL be treated as undefined (REQ-023) and no accumulate logic is synthesized.

Structure
REQ-028 Op codes (MULT, MULTU, DIV, DIVU, MTHI, MTLO, MADD, MADDU, MSUB, MSUBU) and state encodings SHALL live in the shared pipeline package.
REQ-029 No sub-module: FSM, counter and datapath in one module; hi/lo are plain always-block registers.

Verification
REQ-030 MULT rs=0xFFFFFFFE (-2), rt=3 -> busy cycles 1..5, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-031 MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> after 5 busy cycles hi=0xFFFFFFFE, lo=0x00000001.
REQ-032 DIV rs=0xFFFFFFF9 (-7), rt=2 -> 10 busy cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 -> 10 busy cycles, hi/lo unchanged.
REQ-033 MTLO rs=0x1234 -> lo=0x1234 next edge, busy never high; MULT issued while busy -> ignored, first result intact.
REQ-034 Reset asserted in DIV busy cycle 4 -> busy=0, hi=lo=0 immediately, remain 0 after release.
REQ-035 With MULT_DIV_MADD_EN: hi=0, lo=0xFFFFFFFF, MADDU rs=1, rt=1 -> hi=1, lo=0 after 5 busy cycles.
